// File: rtl/bcd_digit_converter_if.sv
// Interface bundling the binary count input and the registered BCD/status outputs.
interface bcd_digit_converter_if #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned BCD_W = 4 * DIGITS;

   logic [BIN_W-1:0] bin_in;
   logic [BCD_W-1:0] bcd_out;
   logic             low_flag;
   logic             busy;
   logic             done;

   modport master (
      output bin_in,
      input  bcd_out,
      input  low_flag,
      input  busy,
      input  done
   );

   modport slave (
      input  bin_in,
      output bcd_out,
      output low_flag,
      output busy,
      output done
   );
endinterface

// File: rtl/bcd_digit_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with input clamp and a
// low-value flag that is registered together with the digits.
module bcd_digit_converter #(
   parameter int unsigned BIN_W   = 14,
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned MAX_VAL = 9999,
   parameter int unsigned THRESH  = 200
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_digit_converter_if.slave  bus
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q,    state_d;
   logic [BIN_W-1:0] last_bin_q, last_bin_d;
   logic [BIN_W-1:0] work_q,     work_d;
   logic [BCD_W-1:0] scratch_q,  scratch_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             low_val_q,  low_val_d;
   logic [BCD_W-1:0] bcd_out_q,  bcd_out_d;
   logic             low_flag_q, low_flag_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;

   logic [BIN_W-1:0] clamped;
   logic [BCD_W-1:0] adjusted;

   // Clamp to the largest displayable value before conversion.
   always_comb begin
      clamped = (bus.bin_in > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bus.bin_in;
   end

   // Add 3 to every digit >= 5 so the following left shift carries correctly.
   always_comb begin
      adjusted = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adjusted[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = adjusted[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      last_bin_d = last_bin_q;
      work_d     = work_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      low_val_d  = low_val_q;
      bcd_out_d  = bcd_out_q;
      low_flag_d = low_flag_q;

      case (state_q)
         IDLE: begin
            if (bus.bin_in != last_bin_q) begin
               last_bin_d = bus.bin_in;
               work_d     = clamped;
               low_val_d  = (clamped < BIN_W'(THRESH));
               scratch_d  = '0;
               cnt_d      = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adjusted[BCD_W-2:0], work_q[BIN_W-1]};
            work_d    = {work_q[BIN_W-2:0], 1'b0};
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_out_d  = scratch_q;
            low_flag_d = low_val_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered from the upcoming state so they align with the digits.
      busy_d = (state_d != IDLE);
      done_d = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_bin_q <= '0;
         work_q     <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         low_val_q  <= 1'b1;
         bcd_out_q  <= '0;
         low_flag_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_bin_q <= last_bin_d;
         work_q     <= work_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         low_val_q  <= low_val_d;
         bcd_out_q  <= bcd_out_d;
         low_flag_q <= low_flag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.bcd_out  = bcd_out_q;
   assign bus.low_flag = low_flag_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
